mult_issue_station: RTL and testbench
=====================================

MULT_ISSUE_STATION -- requirements
Module: mult_issue_station

Interface
REQ-001 Parameter NUM_ENTRIES, default 4, sets the number of station entries (power of two, 2..8).
REQ-002 Parameter TAG_W, default 6, sets the physical register tag width.
REQ-003 Parameter ROB_W, default 5, sets the ROB index width.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset (0 = reset).
REQ-006 dispatch_valid  in  1  dispatch offers one multiply instruction this cycle.
REQ-007 dispatch_ready  out  1  station can accept a dispatch this cycle.
REQ-008 dispatch_mul_type  in  2  multiply variant, passed through to the FU unchanged.
REQ-009 dispatch_ps1, dispatch_ps2, dispatch_pd  in  TAG_W each  source and destination physical tags.
REQ-010 dispatch_ps1_rdy, dispatch_ps2_rdy  in  1 each  source value already available.
REQ-011 dispatch_rob_id  in  ROB_W  ROB slot of the instruction.
REQ-012 cdb_valid  in  1  broadcast of a completed result tag; cdb_tag  in  TAG_W  that tag.
REQ-013 fu_ready  in  1  multiplier FU can accept a start (FU_ready).
REQ-014 fu_done  in  1  FU result valid this cycle (ready_for_writeback).
REQ-015 flush  in  1  squash all waiting and in-flight work.
REQ-016 start_calculate  out  1  one-cycle start pulse to the FU.
REQ-017 issue_valid  out  1  issue_* fields describe a live instruction; writeback discards results when 0.
REQ-018 issue_mul_type (2), issue_ps1, issue_ps2, issue_pd (TAG_W), issue_rob_id (ROB_W)  out  fields of the issued instruction.
REQ-019 occupancy  out  $clog2(NUM_ENTRIES)+1  count of valid entries.

Function
REQ-020 The station holds up to NUM_ENTRIES entries; each entry has valid, age order, both ready bits and all dispatch fields.
REQ-021 dispatch_ready is 1 iff occupancy < NUM_ENTRIES; an entry freed in the same cycle does not raise it.
REQ-022 dispatch_valid && dispatch_ready writes one entry; it becomes selectable in the next cycle.
REQ-023 cdb_valid sets the matching ready bit of every valid entry; a match against a same-cycle dispatch sets that entry's bit too.
REQ-024 An entry is eligible when it is valid and both ready bits are 1; selection takes the oldest eligible entry.
REQ-025 The FSM has four states: IDLE, ISSUE, WAIT and DRAIN.
REQ-026 IDLE -> ISSUE when an eligible entry exists and fu_ready=1; at that edge the entry loads into issue_*, and the entry is freed.
REQ-027 In ISSUE, start_calculate=1 for exactly one cycle, then the FSM goes to WAIT.
REQ-028 WAIT -> IDLE on fu_done=1; issue_* hold stable through the fu_done cycle inclusive.
REQ-029 No new issue in ISSUE, WAIT or DRAIN: at most one instruction is in flight, and the earliest next start is 2 cycles after fu_done.
REQ-030 issue_valid=1 in ISSUE and WAIT, and 0 in IDLE and DRAIN.
REQ-031 Flush clears all entries at the edge; from ISSUE or WAIT the FSM goes to DRAIN, otherwise to IDLE.
REQ-032 DRAIN -> IDLE on fu_done; fu_done arriving in the flush cycle goes directly to IDLE.
REQ-033 Flush has priority over a same-cycle dispatch; that dispatch is dropped.
REQ-034 Flush has priority over a same-cycle issue; that issue is not taken.
REQ-035 Minimum latency from dispatch (both sources ready, FU idle) to start_calculate is 2 cycles: dispatch in cycle t, start in t+2.

Reset
REQ-036 While rst=0, at each edge all entries are invalidated and the FSM goes to IDLE.
REQ-037 During and after reset: start_calculate=0, issue_valid=0, issue_* = 0, occupancy=0, dispatch_ready=1.
REQ-038 Reset mid-WAIT abandons the in-flight operation; the FU is reset by the same signal.

Verification
REQ-039 Dispatch {ps1=3, ps2=4, both rdy, pd=9, rob=2} at cycle 0 with fu_ready=1 -> start_calculate=1 at cycle 2, issue_pd=9, issue_rob_id=2; fu_done at cycle 6 -> IDLE at cycle 7.
REQ-040 Fill 4 entries with ps1_rdy=0, ps1=5 -> dispatch_ready=0 and occupancy=4; cdb_valid with tag 5 -> the oldest entry issues first, and dispatch_ready returns to 1 the cycle after issue.
REQ-041 Dispatch with ps2=7 not ready while cdb_valid carries tag 7 in the same cycle -> entry eligible next cycle and issues at t+2.
REQ-042 Two eligible entries, issue the first, hold fu_done low 10 cycles -> no second start_calculate until 2 cycles after fu_done; issue_* stable throughout.
REQ-043 Flush during WAIT with 2 entries queued -> occupancy=0, issue_valid=0 (DRAIN); fu_done -> IDLE with no start_calculate.
REQ-044 Assert rst=0 mid-WAIT for 1 cycle -> all outputs at reset values on the next cycle; a new dispatch issues normally afterwards.

Source files
------------

// File: rtl/mult_issue_station.sv
// Issue station for a single multiplier FU: buffers dispatched multiplies, wakes them on CDB
// broadcasts and starts the oldest ready one whenever the FU is idle, one operation in flight.
module mult_issue_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 6,
  parameter int ROB_W       = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dispatch_valid,
  output logic                           dispatch_ready,
  input  logic [1:0]                     dispatch_mul_type,
  input  logic [TAG_W-1:0]               dispatch_ps1,
  input  logic [TAG_W-1:0]               dispatch_ps2,
  input  logic [TAG_W-1:0]               dispatch_pd,
  input  logic                           dispatch_ps1_rdy,
  input  logic                           dispatch_ps2_rdy,
  input  logic [ROB_W-1:0]               dispatch_rob_id,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic                           fu_ready,
  input  logic                           fu_done,
  input  logic                           flush,
  output logic                           start_calculate,
  output logic                           issue_valid,
  output logic [1:0]                     issue_mul_type,
  output logic [TAG_W-1:0]               issue_ps1,
  output logic [TAG_W-1:0]               issue_ps2,
  output logic [TAG_W-1:0]               issue_pd,
  output logic [ROB_W-1:0]               issue_rob_id,
  output logic [$clog2(NUM_ENTRIES):0]   occupancy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [1:0]       mul_type;
    logic [TAG_W-1:0] ps1;
    logic [TAG_W-1:0] ps2;
    logic [TAG_W-1:0] pd;
    logic [ROB_W-1:0] rob_id;
  } payload_t;

  state_t                 state_q, state_d;
  logic [NUM_ENTRIES-1:0] valid_q, rdy1_q, rdy2_q;
  payload_t               payload_q [NUM_ENTRIES];
  // older_q[i][j] = 1 when entry i was dispatched before entry j.
  logic [NUM_ENTRIES-1:0] older_q   [NUM_ENTRIES];
  payload_t               issue_q;

  logic [NUM_ENTRIES-1:0] eligible, sel_oh;
  logic [IDX_W-1:0]       sel_idx, free_idx;
  logic                   do_issue, do_dispatch;
  logic                   disp_rdy1, disp_rdy2;

  assign eligible = valid_q & rdy1_q & rdy2_q;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    sel_oh    = '0;
    sel_idx   = '0;
    free_idx  = '0;
    occupancy = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sel_oh[i] = eligible[i] &&
                  ((eligible & ~older_q[i] & ~(NUM_ENTRIES'(1) << i)) == '0);
      if (sel_oh[i]) sel_idx = IDX_W'(i);
      occupancy = occupancy + CNT_W'(valid_q[i]);
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign dispatch_ready = (occupancy < CNT_W'(NUM_ENTRIES));
  assign do_dispatch    = dispatch_valid && dispatch_ready && !flush;
  assign do_issue       = (state_q == IDLE) && (|eligible) && fu_ready && !flush;
  assign disp_rdy1      = dispatch_ps1_rdy || (cdb_valid && (cdb_tag == dispatch_ps1));
  assign disp_rdy2      = dispatch_ps2_rdy || (cdb_valid && (cdb_tag == dispatch_ps2));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (do_issue) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (fu_done) state_d = IDLE;
      DRAIN: if (fu_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush while an operation is in flight must wait for the FU to finish it.
    if (flush) begin
      state_d = ((state_q == ISSUE || state_q == WAIT) && !fu_done) ? DRAIN : IDLE;
    end
  end

  assign start_calculate = (state_q == ISSUE);
  assign issue_valid     = (state_q == ISSUE) || (state_q == WAIT);
  assign issue_mul_type  = issue_q.mul_type;
  assign issue_ps1       = issue_q.ps1;
  assign issue_ps2       = issue_q.ps2;
  assign issue_pd        = issue_q.pd;
  assign issue_rob_id    = issue_q.rob_id;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      issue_q <= '0;
    end else begin
      state_q <= state_d;
      if (do_issue) issue_q <= payload_q[sel_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (valid_q[i] && cdb_valid && (cdb_tag == payload_q[i].ps1)) rdy1_q[i] <= 1'b1;
        if (valid_q[i] && cdb_valid && (cdb_tag == payload_q[i].ps2)) rdy2_q[i] <= 1'b1;
      end
      if (do_issue) valid_q[sel_idx] <= 1'b0;
      if (do_dispatch) begin
        valid_q[free_idx] <= 1'b1;
        rdy1_q[free_idx]  <= disp_rdy1;
        rdy2_q[free_idx]  <= disp_rdy2;
      end
    end
  end

  // NOTE: payload and age storage carry no reset; valid_q gates every use of them.
  always_ff @(posedge clk) begin
    if (do_dispatch) begin
      payload_q[free_idx] <= '{mul_type: dispatch_mul_type, ps1: dispatch_ps1,
                               ps2: dispatch_ps2, pd: dispatch_pd, rob_id: dispatch_rob_id};
      older_q[free_idx]   <= '0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (IDX_W'(j) != free_idx) older_q[j][free_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_issue_station.sv
// Directed bench for mult_issue_station: a per-cycle vector table for the basic issue paths,
// followed by hand-written sequences for ordering, back-pressure, flush and reset corners.
module tb_mult_issue_station;

  logic       clk = 1'b0;
  logic       rst;
  logic       dispatch_valid, dispatch_ready;
  logic [1:0] dispatch_mul_type;
  logic [5:0] dispatch_ps1, dispatch_ps2, dispatch_pd;
  logic       dispatch_ps1_rdy, dispatch_ps2_rdy;
  logic [4:0] dispatch_rob_id;
  logic       cdb_valid;
  logic [5:0] cdb_tag;
  logic       fu_ready, fu_done, flush;
  logic       start_calculate, issue_valid;
  logic [1:0] issue_mul_type;
  logic [5:0] issue_ps1, issue_ps2, issue_pd;
  logic [4:0] issue_rob_id;
  logic [2:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;

  mult_issue_station #(.NUM_ENTRIES(4), .TAG_W(6), .ROB_W(5)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_mul_type(dispatch_mul_type),
    .dispatch_ps1(dispatch_ps1), .dispatch_ps2(dispatch_ps2), .dispatch_pd(dispatch_pd),
    .dispatch_ps1_rdy(dispatch_ps1_rdy), .dispatch_ps2_rdy(dispatch_ps2_rdy),
    .dispatch_rob_id(dispatch_rob_id),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .fu_ready(fu_ready), .fu_done(fu_done), .flush(flush),
    .start_calculate(start_calculate), .issue_valid(issue_valid),
    .issue_mul_type(issue_mul_type), .issue_ps1(issue_ps1), .issue_ps2(issue_ps2),
    .issue_pd(issue_pd), .issue_rob_id(issue_rob_id), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [1:0] mt;
    logic [5:0] ps1;
    logic       r1;
    logic [5:0] ps2;
    logic       r2;
    logic [5:0] pd;
    logic [4:0] rob;
    logic       cv;
    logic [5:0] ctag;
    logic       done;
    logic       e_rdy;
    logic [2:0] e_occ;
    logic       e_start;
    logic       e_iv;
    logic [1:0] e_mt;
    logic [5:0] e_pd;
    logic [4:0] e_rob;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic dv, input logic [1:0] mt, input logic [5:0] ps1,
                              input logic r1, input logic [5:0] ps2, input logic r2,
                              input logic [5:0] pd, input logic [4:0] rob, input logic cv,
                              input logic [5:0] ctag, input logic done, input logic e_rdy,
                              input logic [2:0] e_occ, input logic e_start, input logic e_iv,
                              input logic [1:0] e_mt, input logic [5:0] e_pd,
                              input logic [4:0] e_rob);
    vec_t v;
    v.dv = dv; v.mt = mt; v.ps1 = ps1; v.r1 = r1; v.ps2 = ps2; v.r2 = r2; v.pd = pd;
    v.rob = rob; v.cv = cv; v.ctag = ctag; v.done = done; v.e_rdy = e_rdy; v.e_occ = e_occ;
    v.e_start = e_start; v.e_iv = e_iv; v.e_mt = e_mt; v.e_pd = e_pd; v.e_rob = e_rob;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_valid = 1'b0; dispatch_mul_type = '0;
    dispatch_ps1 = '0; dispatch_ps2 = '0; dispatch_pd = '0; dispatch_rob_id = '0;
    dispatch_ps1_rdy = 1'b0; dispatch_ps2_rdy = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; fu_ready = 1'b1; fu_done = 1'b0; flush = 1'b0;
  endtask

  task automatic disp(input logic [1:0] mt, input logic [5:0] ps1, input logic r1,
                      input logic [5:0] ps2, input logic r2, input logic [5:0] pd,
                      input logic [4:0] rob);
    dispatch_valid = 1'b1; dispatch_mul_type = mt;
    dispatch_ps1 = ps1; dispatch_ps1_rdy = r1;
    dispatch_ps2 = ps2; dispatch_ps2_rdy = r2;
    dispatch_pd = pd; dispatch_rob_id = rob;
  endtask

  // From ISSUE: one WAIT cycle with fu_done, ending in IDLE.
  task automatic finish_op();
    step();
    fu_done = 1'b1;
    step();
    fu_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, start_calculate, 0);
    check({tag, "_iv"}, issue_valid, 0);
    check({tag, "_occ"}, occupancy, 0);
    check({tag, "_drdy"}, dispatch_ready, 1);
    check({tag, "_fields"}, {issue_mul_type, issue_ps1, issue_ps2, issue_pd, issue_rob_id}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    //             dv mt ps1 r1 ps2 r2 pd rob cv ctag dn | rdy occ st iv mt pd rob
    vecs[0]  = mk(1, 1, 3, 1, 4, 1, 9, 2,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 1, 1, 1, 9, 2);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 1, 1, 9, 2);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 1, 1, 9, 2);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 1, 1, 9, 2);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 1, 1, 9, 2);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 3, 1, 1, 7, 0, 10, 3, 1, 7, 0,  1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 1, 1, 3, 10, 3);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 1, 3, 10, 3);
    vecs[12] = mk(1, 0, 2, 1, 8, 0, 11, 4, 1, 9, 0,  1, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 8, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 1, 1, 0, 11, 4);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 1, 0, 11, 4);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0);

    idle_inputs();
    rst = 1'b0;
    step();
    step();
    check_reset_outputs("in_reset");
    rst = 1'b1;
    step();
    check_reset_outputs("post_reset");

    for (int k = 0; k < NV; k++) begin
      dispatch_valid = vecs[k].dv; dispatch_mul_type = vecs[k].mt;
      dispatch_ps1 = vecs[k].ps1; dispatch_ps1_rdy = vecs[k].r1;
      dispatch_ps2 = vecs[k].ps2; dispatch_ps2_rdy = vecs[k].r2;
      dispatch_pd = vecs[k].pd; dispatch_rob_id = vecs[k].rob;
      cdb_valid = vecs[k].cv; cdb_tag = vecs[k].ctag; fu_done = vecs[k].done;
      check($sformatf("vec%0d_drdy", k), dispatch_ready, vecs[k].e_rdy);
      check($sformatf("vec%0d_occ", k), occupancy, vecs[k].e_occ);
      check($sformatf("vec%0d_start", k), start_calculate, vecs[k].e_start);
      check($sformatf("vec%0d_iv", k), issue_valid, vecs[k].e_iv);
      if (vecs[k].e_iv) begin
        check($sformatf("vec%0d_mt", k), issue_mul_type, vecs[k].e_mt);
        check($sformatf("vec%0d_pd", k), issue_pd, vecs[k].e_pd);
        check($sformatf("vec%0d_rob", k), issue_rob_id, vecs[k].e_rob);
      end
      step();
    end
    idle_inputs();

    // Fill to capacity with ps1 waiting on tag 5, then wake all at once.
    for (int k = 0; k < 4; k++) begin
      disp(2, 5, 0, 6'(k + 1), 1, 6'(20 + k), 5'(10 + k));
      step();
    end
    disp(2, 5, 0, 9, 1, 30, 15);
    check("full_drdy", dispatch_ready, 0);
    check("full_occ", occupancy, 4);
    step();
    dispatch_valid = 1'b0;
    check("full_drop_occ", occupancy, 4);
    cdb_valid = 1'b1; cdb_tag = 5;
    check("wake_start0", start_calculate, 0);
    step();
    cdb_valid = 1'b0;
    check("wake_start1", start_calculate, 0);
    step();
    check("oldest_start", start_calculate, 1);
    check("oldest_pd", issue_pd, 20);
    check("oldest_rob", issue_rob_id, 10);
    check("oldest_mt", issue_mul_type, 2);
    check("oldest_occ", occupancy, 3);
    check("drdy_after_issue", dispatch_ready, 1);
    // Younger entry lands in the slot just freed; it must not jump the queue.
    disp(0, 6, 1, 6, 1, 24, 14);
    step();
    dispatch_valid = 1'b0;
    check("refill_occ", occupancy, 4);
    fu_done = 1'b1;
    step();
    fu_done = 1'b0;
    check("idle_iv", issue_valid, 0);
    step();
    check("age_start", start_calculate, 1);
    check("age_pd", issue_pd, 21);

    // Long FU latency: nothing else may start, issue fields hold.
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("hold%0d_start", k), start_calculate, 0);
      check($sformatf("hold%0d_iv", k), issue_valid, 1);
      check($sformatf("hold%0d_pd", k), issue_pd, 21);
      check($sformatf("hold%0d_rob", k), issue_rob_id, 11);
    end
    fu_done = 1'b1;
    step();
    fu_done = 1'b0;
    check("done_plus1_start", start_calculate, 0);
    check("done_plus1_iv", issue_valid, 0);
    step();
    check("done_plus2_start", start_calculate, 1);
    check("done_plus2_pd", issue_pd, 22);
    finish_op();
    step();
    check("third_pd", issue_pd, 23);
    finish_op();
    step();
    check("youngest_pd", issue_pd, 24);
    check("youngest_rob", issue_rob_id, 14);
    finish_op();
    check("drained_occ", occupancy, 0);

    // Flush during WAIT with two entries queued.
    disp(0, 1, 1, 2, 1, 40, 20);
    step();
    disp(0, 12, 0, 2, 1, 41, 21);
    step();
    check("fl_start", start_calculate, 1);
    check("fl_pd", issue_pd, 40);
    disp(0, 13, 0, 2, 1, 42, 22);
    step();
    dispatch_valid = 1'b0;
    check("fl_occ_before", occupancy, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("drain_occ", occupancy, 0);
    check("drain_iv", issue_valid, 0);
    check("drain_start", start_calculate, 0);
    check("drain_drdy", dispatch_ready, 1);
    disp(0, 1, 1, 1, 1, 43, 23);
    step();
    dispatch_valid = 1'b0;
    check("drain_disp_occ", occupancy, 1);
    check("drain_block0", start_calculate, 0);
    step();
    check("drain_block1", start_calculate, 0);
    check("drain_block1_iv", issue_valid, 0);
    fu_done = 1'b1;
    step();
    fu_done = 1'b0;
    check("drain_exit_start", start_calculate, 0);
    check("drain_exit_iv", issue_valid, 0);
    step();
    check("post_drain_start", start_calculate, 1);
    check("post_drain_pd", issue_pd, 43);
    finish_op();

    // fu_ready low blocks issue; flush beats same-cycle issue and dispatch.
    fu_ready = 1'b0;
    disp(0, 1, 1, 1, 1, 50, 24);
    step();
    dispatch_valid = 1'b0;
    step();
    check("fu_busy_start", start_calculate, 0);
    check("fu_busy_occ", occupancy, 1);
    fu_ready = 1'b1;
    flush = 1'b1;
    disp(0, 1, 1, 1, 1, 51, 25);
    step();
    flush = 1'b0;
    dispatch_valid = 1'b0;
    check("flush_prio_occ", occupancy, 0);
    check("flush_prio_start", start_calculate, 0);
    check("flush_prio_iv", issue_valid, 0);
    step();
    check("flush_prio_start2", start_calculate, 0);

    // Reset in the middle of WAIT.
    disp(0, 1, 1, 1, 1, 60, 26);
    step();
    dispatch_valid = 1'b0;
    step();
    check("rst_pre_start", start_calculate, 1);
    check("rst_pre_pd", issue_pd, 60);
    disp(0, 14, 0, 1, 1, 61, 27);
    step();
    dispatch_valid = 1'b0;
    check("rst_pre_iv", issue_valid, 1);
    check("rst_pre_occ", occupancy, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_outputs("mid_wait_reset");
    disp(3, 1, 1, 1, 1, 62, 28);
    step();
    dispatch_valid = 1'b0;
    step();
    check("after_rst_start", start_calculate, 1);
    check("after_rst_pd", issue_pd, 62);
    check("after_rst_mt", issue_mul_type, 3);
    step();
    // fu_done in the flush cycle returns straight to IDLE.
    flush = 1'b1;
    fu_done = 1'b1;
    step();
    flush = 1'b0;
    fu_done = 1'b0;
    check("flush_done_iv", issue_valid, 0);
    disp(0, 1, 1, 1, 1, 63, 29);
    step();
    dispatch_valid = 1'b0;
    step();
    check("flush_done_start", start_calculate, 1);
    check("flush_done_pd", issue_pd, 63);
    finish_op();
    check("final_occ", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
